// File: rtl/game_countdown_if.sv
// Control/status bundle between the game controller and the round countdown.
// master = controller side (drives tick/start/pause), slave = countdown block.
interface game_countdown_if;
   logic       tick_1hz;
   logic       start;
   logic       pause;
   logic [3:0] secs_tens;
   logic [3:0] secs_ones;
   logic       running;
   logic       warning;
   logic       game_over;
   logic       time_up;

   modport master (
      output tick_1hz, start, pause,
      input  secs_tens, secs_ones, running, warning, game_over, time_up
   );

   modport slave (
      input  tick_1hz, start, pause,
      output secs_tens, secs_ones, running, warning, game_over, time_up
   );
endinterface

// File: rtl/game_countdown.sv
// Whack-a-mole round countdown: BCD seconds driven by the 1 Hz tick, with
// start/restart, pause, last-seconds warning and round-end signalling.
module game_countdown #(
   parameter int unsigned GAME_SECONDS = 60,
   parameter int unsigned WARN_SECONDS = 10
) (
   input logic             clk_in,
   input logic             rst_n,
   game_countdown_if.slave bus
);

   localparam logic [3:0] InitTens  = 4'(GAME_SECONDS / 10);
   localparam logic [3:0] InitOnes  = 4'(GAME_SECONDS % 10);
   localparam logic [6:0] WarnLimit = 7'(WARN_SECONDS);
   localparam logic       WarnOn    = (WARN_SECONDS != 0);

   typedef enum logic [1:0] {StIdle, StRunning, StPaused, StDone} state_e;

   state_e     state_q, state_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;
   logic       running_q, warning_q, game_over_q, time_up_q;
   logic [6:0] remain_d;
   logic       warn_d;

   // Next state and digits. Priority in RUNNING is start > pause > tick.
   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRunning;
               tens_d  = InitTens;
               ones_d  = InitOnes;
            end
         end
         StRunning: begin
            if (bus.start) begin
               tens_d = InitTens;
               ones_d = InitOnes;
            end else if (bus.pause) begin
               state_d = StPaused;
            end else if (bus.tick_1hz) begin
               // 01 (or a stray 00) ends the round; digits never wrap below 00.
               if (tens_q == 4'd0 && ones_q <= 4'd1) begin
                  tens_d  = 4'd0;
                  ones_d  = 4'd0;
                  state_d = StDone;
               end else if (ones_q != 4'd0) begin
                  ones_d = ones_q - 4'd1;
               end else begin
                  ones_d = 4'd9;
                  tens_d = tens_q - 4'd1;
               end
            end
         end
         StPaused: begin
            if (bus.start) begin
               state_d = StRunning;
               tens_d  = InitTens;
               ones_d  = InitOnes;
            end else if (!bus.pause) begin
               state_d = StRunning;
            end
         end
         StDone: begin
            if (bus.start) begin
               state_d = StRunning;
               tens_d  = InitTens;
               ones_d  = InitOnes;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Warning tracks the next digits so it moves on the same edge as the display.
   always_comb begin
      remain_d = 7'(tens_d) * 7'd10 + 7'(ones_d);
      warn_d   = WarnOn && (state_d == StRunning || state_d == StPaused) &&
                 (remain_d != 7'd0) && (remain_d <= WarnLimit);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         tens_q      <= InitTens;
         ones_q      <= InitOnes;
         running_q   <= 1'b0;
         warning_q   <= 1'b0;
         game_over_q <= 1'b0;
         time_up_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         running_q   <= (state_d == StRunning);
         warning_q   <= warn_d;
         game_over_q <= (state_d == StDone);
         time_up_q   <= (state_q != StDone) && (state_d == StDone);
      end
   end

   assign bus.secs_tens = tens_q;
   assign bus.secs_ones = ones_q;
   assign bus.running   = running_q;
   assign bus.warning   = warning_q;
   assign bus.game_over = game_over_q;
   assign bus.time_up   = time_up_q;

endmodule

// File: tb/tb_game_countdown.sv
// Bench for game_countdown: integer-seconds reference model checked every cycle
// on two instances (60/10 and 1/0), plus directed literal checks.
module tb_game_countdown;

   localparam int unsigned GsA = 60;
   localparam int unsigned WsA = 10;
   localparam int unsigned GsB = 1;
   localparam int unsigned WsB = 0;

   localparam logic [1:0] MIdle  = 2'd0;
   localparam logic [1:0] MRun   = 2'd1;
   localparam logic [1:0] MPause = 2'd2;
   localparam logic [1:0] MDone  = 2'd3;

   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] rem;
      logic       tu;
   } mstate_t;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b1;
   logic chk_en = 1'b0;
   int   tests  = 0;
   int   fails  = 0;

   mstate_t ms_a, ms_b;

   always #5 clk_in = ~clk_in;

   game_countdown_if bus_a ();
   game_countdown_if bus_b ();

   game_countdown #(.GAME_SECONDS(GsA), .WARN_SECONDS(WsA)) dut_a (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus_a)
   );

   game_countdown #(.GAME_SECONDS(GsB), .WARN_SECONDS(WsB)) dut_b (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus_b)
   );

   // Reference: remaining seconds as a plain integer.
   function automatic mstate_t step(mstate_t s, int gs, logic st, logic pa, logic tk);
      mstate_t n;
      n    = s;
      n.tu = 1'b0;
      if (st) begin
         n.mode = MRun;
         n.rem  = 8'(gs);
      end else if (s.mode == MRun) begin
         if (pa) begin
            n.mode = MPause;
         end else if (tk) begin
            n.rem = (s.rem > 0) ? s.rem - 8'd1 : 8'd0;
            if (n.rem == 0) begin
               n.mode = MDone;
               n.tu   = 1'b1;
            end
         end
      end else if (s.mode == MPause && !pa) begin
         n.mode = MRun;
      end
      return n;
   endfunction

   function automatic logic [11:0] expect_out(mstate_t s, int ws);
      int         r;
      logic       warn;
      r    = int'(s.rem);
      warn = (s.mode == MRun || s.mode == MPause) && r > 0 && r <= ws;
      return {4'(r / 10), 4'(r % 10), s.mode == MRun, warn, s.mode == MDone, s.tu};
   endfunction

   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         ms_a <= '{mode: MIdle, rem: 8'(GsA), tu: 1'b0};
         ms_b <= '{mode: MIdle, rem: 8'(GsB), tu: 1'b0};
      end else begin
         ms_a <= step(ms_a, GsA, bus_a.start, bus_a.pause, bus_a.tick_1hz);
         ms_b <= step(ms_b, GsB, bus_b.start, bus_b.pause, bus_b.tick_1hz);
      end
   end

   // Output order: tens, ones, running, warning, game_over, time_up.
   always @(negedge clk_in) begin
      logic [11:0] act_a, act_b, exp_a, exp_b;
      if (chk_en) begin
         act_a = {bus_a.secs_tens, bus_a.secs_ones, bus_a.running, bus_a.warning,
                  bus_a.game_over, bus_a.time_up};
         act_b = {bus_b.secs_tens, bus_b.secs_ones, bus_b.running, bus_b.warning,
                  bus_b.game_over, bus_b.time_up};
         exp_a = expect_out(ms_a, WsA);
         exp_b = expect_out(ms_b, WsB);
         tests += 2;
         if (act_a !== exp_a) begin
            fails++;
            $display("FAIL cyc_a t=%0t: got %h_%h_%b expected %h_%h_%b", $time,
                     act_a[11:8], act_a[7:4], act_a[3:0], exp_a[11:8], exp_a[7:4], exp_a[3:0]);
         end
         if (act_b !== exp_b) begin
            fails++;
            $display("FAIL cyc_b t=%0t: got %h_%h_%b expected %h_%h_%b", $time,
                     act_b[11:8], act_b[7:4], act_b[3:0], exp_b[11:8], exp_b[7:4], exp_b[3:0]);
         end
      end
   end

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   // One clock with the given pulses on bus A; returns just after the sampling edge.
   task automatic pulse_a(logic st, logic tk);
      bus_a.start    = st;
      bus_a.tick_1hz = tk;
      idle(1);
      bus_a.start    = 1'b0;
      bus_a.tick_1hz = 1'b0;
   endtask

   task automatic ticks_a(int n);
      repeat (n) begin
         pulse_a(1'b0, 1'b1);
         idle(7);
      end
   endtask

   function automatic logic [7:0] digits_a();
      return {bus_a.secs_tens, bus_a.secs_ones};
   endfunction

   initial begin
      bus_a.start = 1'b0; bus_a.pause = 1'b0; bus_a.tick_1hz = 1'b0;
      bus_b.start = 1'b0; bus_b.pause = 1'b0; bus_b.tick_1hz = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_digits_a", 16'(digits_a()), 16'h60);
      chk("reset_flags_a", 16'({bus_a.running, bus_a.warning, bus_a.game_over, bus_a.time_up}),
          16'h0);
      chk("reset_digits_b", 16'({bus_b.secs_tens, bus_b.secs_ones}), 16'h01);
      idle(2);
      rst_n = 1'b1;
      chk_en = 1'b1;

      ticks_a(2);
      chk("idle_ignores_tick", 16'({digits_a(), 7'd0, bus_a.running}), 16'h6000);

      pulse_a(1'b1, 1'b0);
      chk("start_running", 16'({digits_a(), 7'd0, bus_a.running}), 16'h6001);
      ticks_a(3);
      chk("three_ticks", 16'(digits_a()), 16'h57);

      bus_a.pause = 1'b1;
      idle(1);
      ticks_a(5);
      chk("paused_hold", 16'({digits_a(), 6'd0, bus_a.running, bus_a.warning}), 16'h5700);
      bus_a.pause = 1'b0;
      idle(1);
      ticks_a(1);
      chk("resume_tick", 16'(digits_a()), 16'h56);

      ticks_a(6);
      chk("at_50", 16'(digits_a()), 16'h50);
      ticks_a(1);
      chk("bcd_borrow_49", 16'(digits_a()), 16'h49);

      ticks_a(7);
      pulse_a(1'b1, 1'b1);
      chk("start_beats_tick", 16'(digits_a()), 16'h60);
      idle(7);
      ticks_a(18);
      bus_a.pause = 1'b1;
      pulse_a(1'b0, 1'b1);
      chk("pause_beats_tick", 16'({digits_a(), 7'd0, bus_a.running}), 16'h4200);
      bus_a.pause = 1'b0;
      idle(2);

      ticks_a(31);
      chk("at_11_no_warn", 16'({digits_a(), 7'd0, bus_a.warning}), 16'h1100);
      ticks_a(1);
      chk("at_10_warn", 16'({digits_a(), 7'd0, bus_a.warning}), 16'h1001);
      ticks_a(9);
      chk("at_01_warn", 16'({digits_a(), 7'd0, bus_a.warning}), 16'h0101);
      pulse_a(1'b0, 1'b1);
      chk("round_end", 16'({digits_a(), 4'd0, bus_a.running, bus_a.warning, bus_a.game_over,
                            bus_a.time_up}), 16'h0003);
      idle(1);
      chk("time_up_one_cycle", 16'({bus_a.game_over, bus_a.time_up}), 16'b10);
      pulse_a(1'b0, 1'b1);
      chk("done_tick_no_time_up", 16'({digits_a(), 6'd0, bus_a.game_over, bus_a.time_up}),
          16'h0002);
      ticks_a(2);

      pulse_a(1'b1, 1'b0);
      chk("restart_from_done", 16'({digits_a(), 6'd0, bus_a.running, bus_a.game_over}), 16'h6002);
      idle(7);
      ticks_a(37);
      chk("at_23", 16'(digits_a()), 16'h23);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset", 16'({digits_a(), 4'd0, bus_a.running, bus_a.warning, bus_a.game_over,
                              bus_a.time_up}), 16'h6000);
      idle(1);
      rst_n = 1'b1;
      ticks_a(2);
      chk("post_reset_idle", 16'({digits_a(), 7'd0, bus_a.running}), 16'h6000);

      bus_b.start = 1'b1;
      idle(1);
      bus_b.start = 1'b0;
      chk("b_start", 16'({bus_b.secs_tens, bus_b.secs_ones, 6'd0, bus_b.running, bus_b.warning}),
          16'h0102);
      idle(3);
      bus_b.tick_1hz = 1'b1;
      idle(1);
      bus_b.tick_1hz = 1'b0;
      chk("b_done", 16'({bus_b.secs_tens, bus_b.secs_ones, 5'd0, bus_b.warning, bus_b.game_over,
                         bus_b.time_up}), 16'h0003);

      // Random traffic on both instances, checked cycle by cycle against the model.
      for (int i = 0; i < 5000; i++) begin
         bus_a.start    = ($urandom_range(0, 299) == 0);
         bus_a.tick_1hz = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 29) == 0) bus_a.pause = ~bus_a.pause;
         bus_b.start    = ($urandom_range(0, 19) == 0);
         bus_b.tick_1hz = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) bus_b.pause = ~bus_b.pause;
         idle(1);
      end
      bus_a.start = 1'b0; bus_a.tick_1hz = 1'b0; bus_a.pause = 1'b0;
      bus_b.start = 1'b0; bus_b.tick_1hz = 1'b0; bus_b.pause = 1'b0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
